univ_reg_sr: RTL and testbench

- Parametrised universal register: the next generation of the single-bit D flip-flop with reset.
- Holds WIDTH bits and supports eight modes: hold, parallel load, shift left/right, count up/down, rotate left/right.
- Provides complementary outputs, serial outputs and a terminal-count flag for chaining.
- Used as the general storage, shift and counter element in later datapath labs; one clock domain.

---
 rtl/univ_reg_pkg.sv | 13 +
 rtl/dff_sr_en.sv | 24 ++
 rtl/univ_reg_sr.sv | 71 +++++++
 tb/tb_univ_reg_sr.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/univ_reg_pkg.sv
// Shared mode encodings for the universal register and anything that drives it.
package univ_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_INC  = 3'b100;
  localparam logic [2:0] MODE_DEC  = 3'b101;
  localparam logic [2:0] MODE_ROL  = 3'b110;
  localparam logic [2:0] MODE_ROR  = 3'b111;

endpackage

// File: rtl/dff_sr_en.sv
// Single-bit D flop with synchronous active-high reset to a fixed value and a clock enable.
module dff_sr_en #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic r,
  input  logic en,
  input  logic d,
  output logic q
);

  logic r_q;

  // Reset outranks enable so a clear always lands, even while the bit is frozen.
  always_ff @(posedge clk) begin
    if (r)
      r_q <= RST_VAL;
    else if (en)
      r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/univ_reg_sr.sv
// Universal WIDTH-bit register: hold, load, shift, count and rotate, built from per-bit flops.
module univ_reg_sr
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             sout_l,
  output logic             sout_r,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_next;
  logic             w_all_ones;
  logic             w_all_zero;

  always_comb begin
    w_next = w_q;
    case (mode)
      MODE_HOLD: w_next = w_q;
      MODE_LOAD: w_next = d;
      MODE_SHL:  w_next = {w_q[WIDTH-2:0], sin_r};
      MODE_SHR:  w_next = {sin_l, w_q[WIDTH-1:1]};
      MODE_INC:  w_next = w_q + ONE;
      MODE_DEC:  w_next = w_q - ONE;
      MODE_ROL:  w_next = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
      MODE_ROR:  w_next = {w_q[0], w_q[WIDTH-1:1]};
      default:   w_next = w_q;
    endcase
  end

  // The shared enable gates every bit; each bit picks up its own reset value.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      dff_sr_en #(
        .RST_VAL (RESET_VAL[gi])
      ) u_bit (
        .clk (clk),
        .r   (r),
        .en  (en),
        .d   (w_next[gi]),
        .q   (w_q[gi])
      );
    end
  endgenerate

  assign w_all_ones = &w_q;
  assign w_all_zero = ~(|w_q);

  assign q      = w_q;
  assign qn     = ~w_q;
  assign sout_l = w_q[WIDTH-1];
  assign sout_r = w_q[0];

  // Kept combinational so a lower stage's tc can enable the next stage in the same cycle.
  assign tc = en & (((mode == MODE_INC) & w_all_ones) | ((mode == MODE_DEC) & w_all_zero));

endmodule

// File: tb/tb_univ_reg_sr.sv
// Directed bench for univ_reg_sr: reset, load, shifts, counting wraps, mid-count reset, cascade.
module tb_univ_reg_sr;
  import univ_reg_pkg::*;

  logic       clk = 1'b0;
  int         checks = 0;
  int         errors = 0;

  // Main 4-bit instance, reset value 0
  logic       r, en, sinR, sinL;
  logic [2:0] mode;
  logic [3:0] d, q, qn;
  logic       soutL, soutR, tc;

  // 4-bit instance with reset value 0110
  logic       rR, enR;
  logic [2:0] modeR;
  logic [3:0] dR, qR, qnR;
  logic       soutLR, soutRR, tcR;

  // Cascaded pair: low tc enables high
  logic       casR, casEn;
  logic [3:0] loQ, loQn, hiQ, hiQn;
  logic       loSoutL, loSoutR, loTc, hiSoutL, hiSoutR, hiTc;

  always #5 clk = ~clk;

  univ_reg_sr #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
    .clk(clk), .r(r), .en(en), .mode(mode), .d(d), .sin_r(sinR), .sin_l(sinL),
    .q(q), .qn(qn), .sout_l(soutL), .sout_r(soutR), .tc(tc)
  );

  univ_reg_sr #(.WIDTH(4), .RESET_VAL(4'b0110)) dutRst (
    .clk(clk), .r(rR), .en(enR), .mode(modeR), .d(dR), .sin_r(1'b0), .sin_l(1'b0),
    .q(qR), .qn(qnR), .sout_l(soutLR), .sout_r(soutRR), .tc(tcR)
  );

  univ_reg_sr #(.WIDTH(4), .RESET_VAL(4'b0000)) dutLo (
    .clk(clk), .r(casR), .en(casEn), .mode(MODE_INC), .d(4'b0000), .sin_r(1'b0), .sin_l(1'b0),
    .q(loQ), .qn(loQn), .sout_l(loSoutL), .sout_r(loSoutR), .tc(loTc)
  );

  univ_reg_sr #(.WIDTH(4), .RESET_VAL(4'b0000)) dutHi (
    .clk(clk), .r(casR), .en(loTc), .mode(MODE_INC), .d(4'b0000), .sin_r(1'b0), .sin_l(1'b0),
    .q(hiQ), .qn(hiQn), .sout_l(hiSoutL), .sout_r(hiSoutR), .tc(hiTc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    r = 1'b1; en = 1'b0; mode = MODE_HOLD; d = 4'b0000; sinR = 1'b0; sinL = 1'b0;
    tick();
    r = 1'b0;
    checks++;
    if (q !== 4'b0000) begin errors++; $display("[TB] FAIL reset_q: got %b expected %b", q, 4'b0000); end
    checks++;
    if (qn !== 4'b1111) begin errors++; $display("[TB] FAIL reset_qn: got %b expected %b", qn, 4'b1111); end
    checks++;
    if ({soutL, soutR} !== 2'b00) begin errors++; $display("[TB] FAIL reset_sout: got %b expected %b", {soutL, soutR}, 2'b00); end
  endtask

  task automatic test_load();
    en = 1'b1; mode = MODE_LOAD; d = 4'b1010;
    tick();
    checks++;
    if (q !== 4'b1010) begin errors++; $display("[TB] FAIL load_q: got %b expected %b", q, 4'b1010); end
    en = 1'b0; d = 4'b0101;
    tick();
    checks++;
    if (q !== 4'b1010) begin errors++; $display("[TB] FAIL en0_hold_q: got %b expected %b", q, 4'b1010); end
    checks++;
    if (qn !== 4'b0101) begin errors++; $display("[TB] FAIL en0_hold_qn: got %b expected %b", qn, 4'b0101); end
    // Reset level without an edge must not disturb q
    r = 1'b1;
    #2;
    checks++;
    if (q !== 4'b1010) begin errors++; $display("[TB] FAIL reset_no_edge: got %b expected %b", q, 4'b1010); end
    r = 1'b0;
  endtask

  task automatic test_shift();
    en = 1'b1; mode = MODE_SHL; sinR = 1'b1;
    tick();
    checks++;
    if (q !== 4'b0101) begin errors++; $display("[TB] FAIL shl_q: got %b expected %b", q, 4'b0101); end
    checks++;
    if (soutL !== 1'b0) begin errors++; $display("[TB] FAIL shl_sout_l: got %b expected %b", soutL, 1'b0); end
    mode = MODE_SHR; sinL = 1'b1; sinR = 1'b0;
    tick();
    checks++;
    if (q !== 4'b1010) begin errors++; $display("[TB] FAIL shr_q: got %b expected %b", q, 4'b1010); end
    checks++;
    if (soutR !== 1'b0) begin errors++; $display("[TB] FAIL shr_sout_r: got %b expected %b", soutR, 1'b0); end
    mode = MODE_ROL; sinL = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (q !== 4'b0101) begin errors++; $display("[TB] FAIL rol_first_q: got %b expected %b", q, 4'b0101); end
      end
    end
    checks++;
    if (q !== 4'b1010) begin errors++; $display("[TB] FAIL rol4_q: got %b expected %b", q, 4'b1010); end
    mode = MODE_ROR; d = 4'b0011;
    tick();
    checks++;
    if (q !== 4'b0101) begin errors++; $display("[TB] FAIL ror_q: got %b expected %b", q, 4'b0101); end
    mode = MODE_HOLD;
    tick();
    checks++;
    if (q !== 4'b0101) begin errors++; $display("[TB] FAIL hold_q: got %b expected %b", q, 4'b0101); end
  endtask

  task automatic test_count_up();
    en = 1'b1; mode = MODE_LOAD; d = 4'b1110;
    tick();
    mode = MODE_INC;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("[TB] FAIL inc_tc_1110: got %b expected %b", tc, 1'b0); end
    tick();
    checks++;
    if (q !== 4'b1111) begin errors++; $display("[TB] FAIL inc_q_1111: got %b expected %b", q, 4'b1111); end
    checks++;
    if (tc !== 1'b1) begin errors++; $display("[TB] FAIL inc_tc_1111: got %b expected %b", tc, 1'b1); end
    tick();
    checks++;
    if (q !== 4'b0000) begin errors++; $display("[TB] FAIL inc_wrap_q: got %b expected %b", q, 4'b0000); end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("[TB] FAIL inc_wrap_tc: got %b expected %b", tc, 1'b0); end
    mode = MODE_LOAD; d = 4'b1111;
    tick();
    en = 1'b0; mode = MODE_INC;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("[TB] FAIL inc_en0_tc: got %b expected %b", tc, 1'b0); end
    en = 1'b1; mode = MODE_ROL;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("[TB] FAIL other_mode_tc: got %b expected %b", tc, 1'b0); end
  endtask

  task automatic test_count_down();
    en = 1'b1; mode = MODE_LOAD; d = 4'b0001;
    tick();
    mode = MODE_DEC;
    tick();
    checks++;
    if (q !== 4'b0000) begin errors++; $display("[TB] FAIL dec_q_0000: got %b expected %b", q, 4'b0000); end
    checks++;
    if (tc !== 1'b1) begin errors++; $display("[TB] FAIL dec_tc_0000: got %b expected %b", tc, 1'b1); end
    tick();
    checks++;
    if (q !== 4'b1111) begin errors++; $display("[TB] FAIL dec_wrap_q: got %b expected %b", q, 4'b1111); end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("[TB] FAIL dec_wrap_tc: got %b expected %b", tc, 1'b0); end
  endtask

  task automatic test_reset_mid();
    rR = 1'b1; enR = 1'b0; modeR = MODE_HOLD; dR = 4'b0000;
    tick();
    rR = 1'b0;
    checks++;
    if (qR !== 4'b0110) begin errors++; $display("[TB] FAIL rstval_q: got %b expected %b", qR, 4'b0110); end
    checks++;
    if (qnR !== 4'b1001) begin errors++; $display("[TB] FAIL rstval_qn: got %b expected %b", qnR, 4'b1001); end
    enR = 1'b1; modeR = MODE_LOAD; dR = 4'b1010;
    tick();
    modeR = MODE_INC;
    tick();
    checks++;
    if (qR !== 4'b1011) begin errors++; $display("[TB] FAIL mid_pre_q: got %b expected %b", qR, 4'b1011); end
    rR = 1'b1;
    tick();
    rR = 1'b0;
    checks++;
    if (qR !== 4'b0110) begin errors++; $display("[TB] FAIL mid_reset_q: got %b expected %b", qR, 4'b0110); end
    tick();
    checks++;
    if (qR !== 4'b0111) begin errors++; $display("[TB] FAIL mid_resume_q: got %b expected %b", qR, 4'b0111); end
  endtask

  task automatic test_cascade();
    casR = 1'b1; casEn = 1'b0;
    tick();
    casR = 1'b0;
    checks++;
    if ({hiQ, loQ} !== 8'h00) begin errors++; $display("[TB] FAIL cas_reset: got %h expected %h", {hiQ, loQ}, 8'h00); end
    casEn = 1'b1;
    repeat (15) tick();
    checks++;
    if (loTc !== 1'b1) begin errors++; $display("[TB] FAIL cas_lo_tc: got %b expected %b", loTc, 1'b1); end
    tick();
    checks++;
    if ({hiQ, loQ} !== 8'h10) begin errors++; $display("[TB] FAIL cas_16: got %h expected %h", {hiQ, loQ}, 8'h10); end
    repeat (239) tick();
    checks++;
    if ({hiQ, loQ} !== 8'hFF) begin errors++; $display("[TB] FAIL cas_255: got %h expected %h", {hiQ, loQ}, 8'hFF); end
    checks++;
    if (hiTc !== 1'b1) begin errors++; $display("[TB] FAIL cas_hi_tc: got %b expected %b", hiTc, 1'b1); end
    tick();
    checks++;
    if ({hiQ, loQ} !== 8'h00) begin errors++; $display("[TB] FAIL cas_256: got %h expected %h", {hiQ, loQ}, 8'h00); end
    casEn = 1'b0;
  endtask

  initial begin
    r = 1'b0; en = 1'b0; mode = MODE_HOLD; d = '0; sinR = 1'b0; sinL = 1'b0;
    rR = 1'b0; enR = 1'b0; modeR = MODE_HOLD; dR = '0;
    casR = 1'b0; casEn = 1'b0;
    #1;
    test_reset();
    test_load();
    test_shift();
    test_count_up();
    test_count_down();
    test_reset_mid();
    test_cascade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
